// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bus: instruction memory port, decode handoff, stall/redirect controls
interface fetch_unit_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;

    modport master (
        input  stall, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, id_valid, id_pc, id_instr, id_opcode
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, id_valid, id_pc, id_instr, id_opcode
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: one outstanding imem read feeding a 2-entry {pc, instr} queue
module fetch_unit (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_req_pc;
    logic        r_drop;
    logic        w_drop_nxt;
    logic [31:0] r_fifo_pc    [2];
    logic [31:0] r_fifo_instr [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic [1:0]  w_count_nxt;
    logic        w_push;
    logic        w_pop;
    logic        w_latch;
    logic        w_id_valid;
    logic [31:0] w_id_instr;
    logic [31:0] w_target;

    assign w_target = {bus.redirect_pc[31:2], 2'b00};

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop;
        w_latch     = 1'b0;
        // A redirect flushes the queue, so neither push nor pop may take effect that cycle.
        w_push      = (r_state == S_WAIT) && bus.imem_rvalid && !r_drop && !bus.redirect;
        w_pop       = w_id_valid && !bus.stall && !bus.redirect;
        if (bus.redirect) begin
            w_count_nxt = 2'd0;
        end else begin
            w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
        end

        case (r_state)
            S_IDLE: begin
                if (bus.redirect) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_REQ;
                end else if (r_count < 2'd2) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.redirect) begin
                    w_pc_nxt = w_target;
                    if (bus.imem_gnt) begin
                        w_state_nxt = S_WAIT;
                        w_drop_nxt  = 1'b1;
                    end
                end else if (bus.imem_gnt) begin
                    w_state_nxt = S_WAIT;
                    w_latch     = 1'b1;
                    w_pc_nxt    = r_pc + 32'd4;
                end
            end
            S_WAIT: begin
                if (bus.redirect) begin
                    w_pc_nxt = w_target;
                    if (bus.imem_rvalid) begin
                        w_state_nxt = S_REQ;
                        w_drop_nxt  = 1'b0;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end else if (bus.imem_rvalid) begin
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = (w_count_nxt < 2'd2) ? S_REQ : S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
            r_drop   <= 1'b0;
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_drop  <= w_drop_nxt;
            r_count <= w_count_nxt;
            if (w_latch) begin
                r_req_pc <= r_pc;
            end
            if (bus.redirect) begin
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_fifo_pc[r_wr_ptr]    <= r_req_pc;
                    r_fifo_instr[r_wr_ptr] <= bus.imem_rdata;
                    r_wr_ptr               <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
            end
        end
    end

    assign w_id_valid    = (r_count != 2'd0);
    assign w_id_instr    = w_id_valid ? r_fifo_instr[r_rd_ptr] : NOP_INSTR;
    assign bus.imem_req  = (r_state == S_REQ);
    assign bus.imem_addr = r_pc;
    assign bus.id_valid  = w_id_valid;
    assign bus.id_pc     = w_id_valid ? r_fifo_pc[r_rd_ptr] : 32'd0;
    assign bus.id_instr  = w_id_instr;
    assign bus.id_opcode = w_id_instr[6:0];
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed-vector bench for fetch_unit
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if ifc ();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic        mem_auto;
    logic        auto_rv = 1'b0;
    logic [31:0] auto_rd = 32'd0;
    logic        man_rv;
    logic [31:0] man_rd;
    logic        mp;
    logic [31:0] ma;

    assign ifc.imem_rvalid = mem_auto ? auto_rv : man_rv;
    assign ifc.imem_rdata  = mem_auto ? auto_rd : man_rd;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[24:0], 7'h33};
    endfunction

    // Memory model: data one cycle after a granted request.
    always @(posedge clk) begin
        mp = ifc.imem_req && ifc.imem_gnt;
        ma = ifc.imem_addr;
        #1;
        auto_rv = mp;
        auto_rd = instr_of(ma);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst             = 1'b1;
        ifc.stall       = 1'b0;
        ifc.redirect    = 1'b0;
        ifc.redirect_pc = 32'd0;
        ifc.imem_gnt    = 1'b1;
        mem_auto        = 1'b1;
        man_rv          = 1'b0;
        man_rd          = 32'd0;

        step(); step();
        check("rst_req",    32'(ifc.imem_req),  32'd0);
        check("rst_addr",   ifc.imem_addr,      32'h0000_0000);
        check("rst_valid",  32'(ifc.id_valid),  32'd0);
        check("rst_instr",  ifc.id_instr,       32'h0000_0013);
        check("rst_opcode", 32'(ifc.id_opcode), 32'h13);
        check("rst_pc",     ifc.id_pc,          32'd0);

        // Streaming: one request every two cycles.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("str_req1", 32'(ifc.imem_req), 32'd1);
            check("str_addr", ifc.imem_addr, 32'(4 * i));
            if (i > 0) begin
                check("str_valid", 32'(ifc.id_valid), 32'd1);
                check("str_pc",    ifc.id_pc, 32'(4 * (i - 1)));
                check("str_instr", ifc.id_instr, instr_of(32'(4 * (i - 1))));
            end
            step();
            check("str_req0", 32'(ifc.imem_req), 32'd0);
        end

        // Stall: queue fills to two, fetching stops, order preserved on release.
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        ifc.stall = 1'b1;
        repeat (8) step();
        check("stl_req",   32'(ifc.imem_req), 32'd0);
        check("stl_addr",  ifc.imem_addr, 32'd8);
        check("stl_valid", 32'(ifc.id_valid), 32'd1);
        check("stl_pc",    ifc.id_pc, 32'd0);
        check("stl_instr", ifc.id_instr, instr_of(32'd0));
        ifc.stall = 1'b0;
        step();
        check("stl_pc2",   ifc.id_pc, 32'd4);
        check("stl_ins2",  ifc.id_instr, instr_of(32'd4));
        check("stl_req2",  32'(ifc.imem_req), 32'd0);
        step();
        check("stl_req3",  32'(ifc.imem_req), 32'd1);
        check("stl_addr3", ifc.imem_addr, 32'd8);
        check("stl_val3",  32'(ifc.id_valid), 32'd0);
        step(); step();
        check("stl_pc4",   ifc.id_pc, 32'd8);
        check("stl_ins4",  ifc.id_instr, instr_of(32'd8));

        // Redirect in WAIT with no response yet: response dropped, refetch at aligned target.
        rst = 1'b1;
        mem_auto = 1'b0;
        man_rv = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        check("rdw_req1", 32'(ifc.imem_req), 32'd1);
        check("rdw_adr1", ifc.imem_addr, 32'd0);
        step();
        check("rdw_req0", 32'(ifc.imem_req), 32'd0);
        ifc.redirect = 1'b1;
        ifc.redirect_pc = 32'h0000_0103;
        step();
        ifc.redirect = 1'b0;
        check("rdw_addr", ifc.imem_addr, 32'h0000_0100);
        check("rdw_req",  32'(ifc.imem_req), 32'd0);
        check("rdw_val",  32'(ifc.id_valid), 32'd0);
        man_rv = 1'b1;
        man_rd = 32'hDEAD_BEEF;
        step();
        man_rv = 1'b0;
        check("drp_req",  32'(ifc.imem_req), 32'd1);
        check("drp_addr", ifc.imem_addr, 32'h0000_0100);
        check("drp_val",  32'(ifc.id_valid), 32'd0);
        step();
        man_rv = 1'b1;
        man_rd = 32'h0000_0537;
        step();
        man_rv = 1'b0;
        check("tgt_val",   32'(ifc.id_valid), 32'd1);
        check("tgt_pc",    ifc.id_pc, 32'h0000_0100);
        check("tgt_instr", ifc.id_instr, 32'h0000_0537);
        check("tgt_opc",   32'(ifc.id_opcode), 32'h37);
        check("tgt_addr",  ifc.imem_addr, 32'h0000_0104);

        // Redirect coinciding with rvalid while holding one entry.
        ifc.stall = 1'b1;
        step();
        check("rdv_val1", 32'(ifc.id_valid), 32'd1);
        man_rv = 1'b1;
        man_rd = 32'h1111_1111;
        ifc.redirect = 1'b1;
        ifc.redirect_pc = 32'h0000_0200;
        step();
        man_rv = 1'b0;
        ifc.redirect = 1'b0;
        ifc.stall = 1'b0;
        check("rdv_val0",  32'(ifc.id_valid), 32'd0);
        check("rdv_instr", ifc.id_instr, 32'h0000_0013);
        check("rdv_req",   32'(ifc.imem_req), 32'd1);
        check("rdv_addr",  ifc.imem_addr, 32'h0000_0200);

        // Redirect on a granted request, then PC wrap at the top of memory.
        ifc.redirect = 1'b1;
        ifc.redirect_pc = 32'hFFFF_FFFF;
        step();
        ifc.redirect = 1'b0;
        check("rdg_req",  32'(ifc.imem_req), 32'd0);
        check("rdg_addr", ifc.imem_addr, 32'hFFFF_FFFC);
        man_rv = 1'b1;
        man_rd = 32'h2222_2222;
        step();
        man_rv = 1'b0;
        check("rdg_req1", 32'(ifc.imem_req), 32'd1);
        check("rdg_val",  32'(ifc.id_valid), 32'd0);
        step();
        check("wrap_addr", ifc.imem_addr, 32'h0000_0000);
        man_rv = 1'b1;
        man_rd = 32'h0000_00EF;
        step();
        man_rv = 1'b0;
        check("wrap_pc",  ifc.id_pc, 32'hFFFF_FFFC);
        check("wrap_opc", 32'(ifc.id_opcode), 32'h6F);
        check("wrap_req", 32'(ifc.imem_req), 32'd1);

        // No grant: request held stable; stray rvalid outside WAIT ignored.
        ifc.imem_gnt = 1'b0;
        man_rv = 1'b1;
        man_rd = 32'h3333_3333;
        step();
        man_rv = 1'b0;
        check("ng_req",  32'(ifc.imem_req), 32'd1);
        check("ng_addr", ifc.imem_addr, 32'd0);
        check("ng_val",  32'(ifc.id_valid), 32'd0);
        step();
        check("ng_req2",  32'(ifc.imem_req), 32'd1);
        check("ng_addr2", ifc.imem_addr, 32'd0);
        ifc.imem_gnt = 1'b1;

        // Reset in WAIT (overriding a redirect); late response ignored.
        step();
        check("rw_req",  32'(ifc.imem_req), 32'd0);
        check("rw_addr", ifc.imem_addr, 32'd4);
        rst = 1'b1;
        ifc.redirect = 1'b1;
        ifc.redirect_pc = 32'h0000_0300;
        step();
        rst = 1'b0;
        ifc.redirect = 1'b0;
        man_rv = 1'b1;
        man_rd = 32'h4444_4444;
        check("rr_req",  32'(ifc.imem_req), 32'd0);
        check("rr_addr", ifc.imem_addr, 32'd0);
        check("rr_val",  32'(ifc.id_valid), 32'd0);
        step();
        man_rv = 1'b0;
        check("rr_val2",  32'(ifc.id_valid), 32'd0);
        check("rr_opc",   32'(ifc.id_opcode), 32'h13);
        check("rr_instr", ifc.id_instr, 32'h0000_0013);
        check("rr_req2",  32'(ifc.imem_req), 32'd1);
        check("rr_addr2", ifc.imem_addr, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
